// File: rtl/rtc_respondedor_bus_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rtc_respondedor_bus_if                                           |
// | Brief    : strobes and status of the RTC responder bus (data bus is a pin) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface rtc_respondedor_bus_if;
    logic       cs_n;
    logic       ad;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] dir_actual;
    logic       error_bus;

    modport master (output cs_n, ad, rd_n, wr_n, input  dir_actual, error_bus);
    modport slave  (input  cs_n, ad, rd_n, wr_n, output dir_actual, error_bus);
endinterface
`default_nettype wire

// File: rtl/rtc_respondedor_bus.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rtc_respondedor_bus                                              |
// | Brief    : responder on the muxed 8-bit RTC bus, 16-byte register file;    |
// |            RESPONDEDOR_RELOJ_EN turns regs 0x00-0x02 into a BCD clock      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rtc_respondedor_bus #(
    parameter int PRESCALE = 100000000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    inout  wire       [7:0]        salient,
    rtc_respondedor_bus_if.slave   bus
);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("PRESCALE must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    logic       s_cs_n_q, s_ad_q, s_rd_n_q, s_wr_n_q;
    logic [7:0] s_sal_q;

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] rdata_q, rdata_d;
    logic       oe_q, oe_d;
    logic       err_q, err_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];

    logic both_low;
    assign both_low = !s_rd_n_q && !s_wr_n_q;

`ifdef RESPONDEDOR_RELOJ_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q;
    logic          tick_w;
    logic          commit_w;
    logic          c_sec, c_min;
    logic [7:0]    sec_n, min_n, hr_n;

    assign tick_w   = (presc_q == PW'(PRESCALE - 1));
    // Any data-register commit suppresses the coincident tick entirely.
    assign commit_w = (state_q == WRITE) && !both_low && (s_wr_n_q || s_cs_n_q)
                      && phase_q && (addr_q < 8'h10);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
        else                return v + 8'd1;
    endfunction

    always_comb begin
        c_sec = (regs_q[0] >= 8'h59);
        sec_n = c_sec ? 8'h00 : bcd_inc(regs_q[0]);
        c_min = c_sec && (regs_q[1] >= 8'h59);
        min_n = !c_sec ? regs_q[1] : (c_min ? 8'h00 : bcd_inc(regs_q[1]));
        hr_n  = !c_min ? regs_q[2] : ((regs_q[2] >= 8'h23) ? 8'h00 : bcd_inc(regs_q[2]));
    end

    always_ff @(posedge clk) begin
        if (reset)       presc_q <= '0;
        else if (tick_w) presc_q <= '0;
        else             presc_q <= presc_q + PW'(1);
    end
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cap_d   = cap_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        oe_d    = oe_q;
        err_d   = 1'b0;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (!s_cs_n_q) begin
                    if (both_low || (!s_rd_n_q && !s_ad_q)) begin
                        err_d = 1'b1;
                    end else if (!s_wr_n_q) begin
                        state_d = WRITE;
                        phase_d = s_ad_q;
                        cap_d   = s_sal_q;
                    end else if (!s_rd_n_q) begin
                        state_d = READ;
                        rdata_d = (addr_q < 8'h10) ? regs_q[addr_q[3:0]] : 8'h00;
                        oe_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (both_low) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (s_wr_n_q || s_cs_n_q) begin
                    state_d = IDLE;
                    if (!phase_q)              addr_d = cap_q;
                    else if (addr_q < 8'h10)   regs_d[addr_q[3:0]] = cap_q;
                end else begin
                    cap_d = s_sal_q;
                end
            end
            READ: begin
                if (both_low) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end else if (s_rd_n_q || s_cs_n_q) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end
        endcase
`ifdef RESPONDEDOR_RELOJ_EN
        if (tick_w && !commit_w) begin
            regs_d[0] = sec_n;
            regs_d[1] = min_n;
            regs_d[2] = hr_n;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_cs_n_q <= 1'b1;
            s_ad_q   <= 1'b0;
            s_rd_n_q <= 1'b1;
            s_wr_n_q <= 1'b1;
            s_sal_q  <= 8'h00;
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            cap_q    <= 8'h00;
            addr_q   <= 8'h00;
            rdata_q  <= 8'h00;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else begin
            s_cs_n_q <= bus.cs_n;
            s_ad_q   <= bus.ad;
            s_rd_n_q <= bus.rd_n;
            s_wr_n_q <= bus.wr_n;
            s_sal_q  <= salient;
            state_q  <= state_d;
            phase_q  <= phase_d;
            cap_q    <= cap_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            oe_q     <= oe_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
        end
    end

    assign salient        = oe_q ? rdata_q : 8'hzz;
    assign bus.dir_actual = addr_q;
    assign bus.error_bus  = err_q;

endmodule
`default_nettype wire

// File: doc/rtc_respondedor_bus.md
# rtc_respondedor_bus

Responder end of the multiplexed 8-bit address/data bus our RTC interface drives. Sits on the shared `salient` bus opposite the host-side bus driver. It latches an address on an address-phase write, stores data on a data-phase write, and drives register contents during a data-phase read. It backs a 16-byte register file that can optionally run a BCD seconds/minutes/hours clock; used as synthesizable RTC stand-in and as the bench responder for the host-side controller.

## Interface
- `PRESCALE`, default 100000000: clk cycles per one-second tick (clock feature only); minimum 2.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `cs_n` input 1: chip select, active low.
- `ad` input 1: phase select; 0 = address phase, 1 = data phase.
- `rd_n` input 1: read strobe, active low.
- `wr_n` input 1: write strobe, active low.
- `salient` inout 8: shared address/data bus; driven only in READ state, else 8'hzz.
- `dir_actual` output 8: current latched address.
- `error_bus` output 1: one-cycle pulse on illegal strobe combination.

## Operation
- Input stage: `cs_n`, `ad`, `rd_n`, `wr_n` and `salient` registered once into `s_*` each edge; the FSM uses only `s_*`.
- `reset`: FSM to IDLE; address 8'h00; all 16 registers 8'h00; prescaler 0; bus released; `dir_actual`=8'h00, `error_bus`=0.
- FSM states IDLE, WRITE, READ.
- IDLE -> WRITE: `s_cs_n`=0, `s_wr_n`=0, `s_rd_n`=1. Latch `s_ad` as phase.
- IDLE -> READ: `s_cs_n`=0, `s_rd_n`=0, `s_wr_n`=1, `s_ad`=1. Snapshot register[addr] into output latch; enable drive.
- IDLE, `s_cs_n`=0, both strobes low: pulse `error_bus`, stay IDLE.
- IDLE, `s_cs_n`=0, `s_rd_n`=0, `s_ad`=0: address-phase read is illegal. Pulse `error_bus`, stay IDLE.
- WRITE: capture `s_salient` each cycle.
- WRITE -> IDLE on `s_wr_n`=1 or `s_cs_n`=1, committing the last captured byte:
  - address phase: store into address register.
  - data phase: store into register[addr[3:0]] if addr < 8'h10; else discard.
- READ: drive snapshot on `salient`; snapshot held constant for the whole strobe.
- READ -> IDLE on `s_rd_n`=1 or `s_cs_n`=1; release bus on that edge.
- Reads of addr >= 8'h10 return 8'h00.
- Both strobes low while in WRITE or READ: pulse `error_bus`, abort to IDLE without commit, release bus.
- No address auto-increment.

## Timing
- Bus driven from the 2nd rising edge after `rd_n` falls (1 sync + 1 FSM).
- Bus released at the 2nd rising edge after `rd_n` rises.
- Write commit visible in the register at the 2nd rising edge after `wr_n` rises.
- A read starting 1 cycle after a commit returns the new value.
- Back-to-back transfers need ≥1 IDLE cycle, i.e. strobes high ≥2 clk.
- `reset` mid-transfer: immediate return to IDLE; bus released that edge; no commit.

## Configuration
- `RESPONDEDOR_RELOJ_EN` defined: registers 0x00/0x01/0x02 are BCD seconds/minutes/hours.
  - Prescaler counts 0..PRESCALE-1; the tick occurs at PRESCALE-1.
  - On a tick, seconds increment: value ≥ 8'h59 -> 8'h00 with carry; else low nibble ≥9 -> {high+1,0}; else +1.
  - Minutes use the same rule on carry.
  - Hours wrap at ≥ 8'h23 -> 8'h00.
  - A host commit in the same cycle as a tick wins; that entire tick is discarded.
  - READ snapshots the value present at READ entry.
- Not defined: no prescaler logic; registers 0x00-0x02 are plain storage.

## Test plan
- Address write 8'h05, data write 8'hA7, read -> `salient`=8'hA7; `dir_actual`=8'h05; bus 8'hzz outside READ.
- Address 8'h20, data write 8'h11, read -> 8'h00; registers unchanged.
- `rd_n`, `wr_n` low together with `cs_n` low -> single-cycle `error_bus`, no commit, bus Z.
- `reset` mid-READ -> bus 8'hzz next edge; register file cleared.
- Clock feature, PRESCALE=4: write 0x00=8'h59, 0x01=8'h59, 0x02=8'h23; after one tick all read 8'h00.
- Clock feature, PRESCALE=4: commit 8'h30 to 0x00 in the tick cycle -> reads 8'h30, not 8'h31.
